// File: rtl/outport_handshake.sv
// -----------------------------------------------------------------------------
// outport_handshake
//
// Output-port side of the CPU handshake. The CPU pushes bytes into a small
// FIFO. The head byte is shown to an external consumer (LEDs) together with a
// valid flag. Each rising edge of the consumer's acknowledge switch pops one
// entry. The registered full flag is returned to the CPU so software can poll
// it before it writes.
//
// Ports
//   clk       system clock
//   nReset    asynchronous active-low reset
//   wr_en     CPU write strobe, one push per cycle while high
//   wr_data   byte written by the CPU
//   ack       consumer acknowledge level, asynchronous to clk
//   data_out  head-of-queue byte (registered)
//   valid     data_out holds an unconsumed byte (registered)
//   full      queue holds DEPTH entries (registered)
//   count     current occupancy (registered)
//   overflow  sticky flag: a write was dropped because the queue was full
//
// DEPTH must be a power of two and at least 2, so the pointers can wrap
// naturally.
// -----------------------------------------------------------------------------
module outport_handshake #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     ack,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             ack_s1_q, ack_s1_d;
    logic             ack_s_q,  ack_s_d;
    logic             ack_d_q,  ack_d_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full_q,   full_d;
    logic             valid_q,  valid_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic ack_rise;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        ack_s1_d = ack;
        ack_s_d  = ack_s1_q;
        ack_d_d  = ack_s_q;

        ack_rise = ack_s_q & ~ack_d_q;
        // A rise seen while the queue is empty is simply lost.
        pop      = ack_rise & (count_q != '0);
        // A write into a full queue fits only when the same cycle frees a slot.
        push     = wr_en & (~full_q | pop);
        drop     = wr_en & full_q & ~pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
        end

        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        full_d     = (count_d == CW'(DEPTH));
        valid_d    = (count_d != '0);
        overflow_d = overflow_q | drop;

        // The head is read from the post-write array, so a push into an empty
        // queue (or a push+pop at count 1) shows the new byte one cycle later.
        // With nothing left the LEDs keep showing the last byte.
        data_out_d = valid_d ? mem_d[rd_ptr_d] : data_out_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ack_s1_q   <= 1'b0;
            ack_s_q    <= 1'b0;
            ack_d_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            ack_s1_q   <= ack_s1_d;
            ack_s_q    <= ack_s_d;
            ack_d_q    <= ack_d_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset: clearing the pointers and the count empties the
    // queue, and the output path never reads a slot that has not been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_outport_handshake.sv
module tb_outport_handshake;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             nReset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             ack;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             full;
    logic [2:0]       count;
    logic             overflow;

    outport_handshake #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ack      (ack),
        .data_out (data_out),
        .valid    (valid),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int v;
        int f;
        int c;
        int o;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain byte queue, a sticky overflow flag and the
    // last byte shown. The acknowledge is seen through a two-sample delay,
    // and a pop is a 0->1 step in that delayed sample stream.
    int m_q[$];
    int m_last;
    int m_ovf;
    int h1, h2, h3;   // ack samples taken 1, 2 and 3 edges before the next one
    int ack_lvl;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = 0;
        m_ovf  = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    // Called at a negedge: drive the inputs for the next posedge, predict the
    // outputs after it, queue the prediction and move on to the next negedge.
    task automatic cycle(input int wr, input int d, input int a);
        exp_t e;
        int   do_pop;
        wr_en   = wr[0];
        wr_data = d[WIDTH-1:0];
        ack     = a[0];
        ack_lvl = a;

        do_pop = (h2 == 1 && h3 == 0 && m_q.size() > 0);
        if (do_pop) void'(m_q.pop_front());
        if (wr != 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(d & 8'hFF);
            else m_ovf = 1;
        end
        if (m_q.size() > 0) m_last = m_q[0];
        h3 = h2; h2 = h1; h1 = a;

        e.d = m_last;
        e.v = (m_q.size() != 0);
        e.f = (m_q.size() == DEPTH);
        e.c = m_q.size();
        e.o = m_ovf;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, ack_lvl);
    endtask

    task automatic press();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear
    // without waiting for a clock. Ends on a negedge with reset released.
    task automatic do_reset(input int check_now);
        @(posedge clk);
        #3;
        nReset  = 1'b0;
        wr_en   = 1'b0;
        ack     = 1'b0;
        ack_lvl = 0;
        #1;
        if (check_now != 0) begin
            chk("rst_data_out", int'(data_out), 0);
            chk("rst_valid",    int'(valid),    0);
            chk("rst_full",     int'(full),     0);
            chk("rst_count",    int'(count),    0);
            chk("rst_overflow", int'(overflow), 0);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_out", int'(data_out), e.d);
            chk("valid",    int'(valid),    e.v);
            chk("full",     int'(full),     e.f);
            chk("count",    int'(count),    e.c);
            chk("overflow", int'(overflow), e.o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset  = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        ack     = 1'b0;
        ack_lvl = 0;
        model_reset();
        #1;
        chk("por_valid", int'(valid), 0);
        chk("por_count", int'(count), 0);
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;

        // single byte, 1-cycle latency
        idle(2);
        cycle(1, 8'hA5, 0);
        idle(2);

        // fill, then a dropped fifth write
        do_reset(1);
        cycle(1, 8'h01, 0); cycle(1, 8'h02, 0);
        cycle(1, 8'h03, 0); cycle(1, 8'h04, 0);
        cycle(1, 8'h05, 0);
        idle(2);

        // held ack gives exactly one pop; second press empties
        do_reset(1);
        cycle(1, 8'h01, 0); cycle(1, 8'h02, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        idle(0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);

        // push into a full queue in the same cycle as a pop
        do_reset(1);
        cycle(1, 8'h01, 0); cycle(1, 8'h02, 0);
        cycle(1, 8'h03, 0); cycle(1, 8'h04, 0);
        idle(2);
        cycle(0, 0, 1); cycle(0, 0, 1); cycle(1, 8'h09, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) press();

        // ack on an empty queue is not remembered
        do_reset(1);
        cycle(0, 0, 1);
        idle(0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        cycle(1, 8'h3C, 0);
        idle(6);

        // ack already high when reset releases
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        cycle(1, 8'h5A, 1);
        idle(4);

        // count 3 with overflow set, then reset mid-cycle
        do_reset(1);
        cycle(1, 8'h01, 0); cycle(1, 8'h02, 0);
        cycle(1, 8'h03, 0); cycle(1, 8'h04, 0);
        cycle(1, 8'h05, 0);
        press();
        do_reset(1);
        cycle(1, 8'h77, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int wr;
            int a;
            wr = ($urandom_range(0, 99) < 40) ? 1 : 0;
            a  = ack_lvl;
            if ($urandom_range(0, 99) < 25) a = 1 - a;
            cycle(wr, $urandom_range(0, 255), a);
            if ($urandom_range(0, 999) == 0) do_reset(1);
        end
        idle(3);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
